// File: rtl/weighted_fcfs_arbiter.sv
// First-come-first-served arbiter with an arrival queue of per-cycle request
// vectors, round-robin tie breaking within an entry, and weight-capped tenure.
module weighted_fcfs_arbiter #(
  parameter int N     = 4,
  parameter int DEPTH = 4,
  parameter int WW    = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  input  logic [N*WW-1:0]      weight,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_id,
  output logic                 queue_empty,
  output logic                 queue_full,
  output logic                 overflow
);

  localparam int IW = $clog2(N);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t         state;
  logic [N-1:0]   grant_q;
  logic [N-1:0]   req_q;
  logic [IW-1:0]  owner;
  logic [IW-1:0]  ptr;
  logic [WW-1:0]  cnt;
  logic [N-1:0]   q [DEPTH];
  logic [PW-1:0]  rd_ptr;
  logic [PW-1:0]  wr_ptr;
  logic [CW-1:0]  count;
  logic           ovf_q;

  logic           tenure_end;
  logic           free;
  logic           use_queue;
  logic           bypass;
  logic [N-1:0]   requeue;
  logic [N-1:0]   arrival;
  logic [N-1:0]   head;
  logic [N-1:0]   pool;
  logic           pick_found;
  logic [IW-1:0]  pick_idx;
  logic [IW-1:0]  cand;
  logic [N-1:0]   pick_vec;
  logic [WW-1:0]  pick_w;
  logic [WW-1:0]  load;
  logic           pop;
  logic [N-1:0]   push_vec;
  logic           do_push;
  logic           merge;
  logic [PW-1:0]  tail;

  always_comb begin
    tenure_end = (state == GRANT) && (!req[owner] || cnt == WW'(1));
    requeue    = (state == GRANT && cnt == WW'(1) && req[owner]) ? grant_q : '0;
    arrival    = (req & ~req_q) | requeue;
    free       = (state == IDLE) || tenure_end;
    head       = q[rd_ptr] & req;
    use_queue  = free && (count != '0);
    // Bypass only from a settled IDLE; a tenure that ends with an empty
    // queue parks its arrivals (including the requeue) for one bubble.
    bypass     = (state == IDLE) && (count == '0);
    pool       = use_queue ? head : (bypass ? arrival : '0);

    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IW'((int'(ptr) + k) % N);
      if (!pick_found && pool[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
    pick_vec = pick_found ? (N'(1) << pick_idx) : '0;
    pick_w   = weight[pick_idx*WW +: WW];
    load     = (pick_w == '0) ? WW'(1) : pick_w;

    pop      = use_queue && ((head & ~pick_vec) == '0);
    push_vec = bypass ? (arrival & ~pick_vec) : arrival;
    do_push  = (push_vec != '0);
    merge    = do_push && ((count - CW'(pop)) == CW'(DEPTH));
    tail     = wr_ptr - PW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      grant_q <= '0;
      req_q   <= '0;
      owner   <= '0;
      ptr     <= IW'(N - 1);
      cnt     <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      ovf_q   <= 1'b0;
      // NOTE: queue contents are not reset; count alone defines which entries
      // are valid, so stale data is never observed.
    end else begin
      req_q <= req;
      ovf_q <= merge;
      for (int k = 0; k < DEPTH; k++) q[k] <= q[k] & req;

      if (free) begin
        if (pick_found) begin
          state   <= GRANT;
          grant_q <= pick_vec;
          owner   <= pick_idx;
          ptr     <= pick_idx;
          cnt     <= load;
          if (use_queue && !pop) q[rd_ptr] <= head & ~pick_vec;
        end else begin
          state   <= IDLE;
          grant_q <= '0;
          cnt     <= '0;
        end
      end else begin
        cnt <= cnt - WW'(1);
      end

      if (pop) rd_ptr <= rd_ptr + PW'(1);

      // NOTE: these writes follow the masking loop on purpose; the last
      // non-blocking assignment to an entry wins within the edge.
      if (do_push) begin
        if (merge) begin
          q[tail] <= (q[tail] & req) | push_vec;
        end else begin
          q[wr_ptr] <= push_vec;
          wr_ptr    <= wr_ptr + PW'(1);
        end
      end

      count <= count - CW'(pop) + CW'(do_push && !merge);
    end
  end

  assign grant       = grant_q & req;
  assign grant_id    = owner;
  assign queue_empty = (count == '0);
  assign queue_full  = (count == CW'(DEPTH));
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_weighted_fcfs_arbiter.sv
// Directed plus randomized bench for weighted_fcfs_arbiter, checked every cycle
// against a queue-based reference model of the arbitration rules.
module tb_weighted_fcfs_arbiter;

  localparam int N     = 4;
  localparam int DEPTH = 4;
  localparam int WW    = 4;
  localparam int IW    = $clog2(N);

  logic              clk;
  logic              rst_n;
  logic [N-1:0]      req;
  logic [N*WW-1:0]   weight;
  logic [N-1:0]      grant;
  logic [IW-1:0]     grant_id;
  logic              queue_empty;
  logic              queue_full;
  logic              overflow;

  int checks = 0;
  int errors = 0;

  weighted_fcfs_arbiter #(.N(N), .DEPTH(DEPTH), .WW(WW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .weight      (weight),
    .grant       (grant),
    .grant_id    (grant_id),
    .queue_empty (queue_empty),
    .queue_full  (queue_full),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: owner index (-1 = none), remaining tenure cycles,
  // round-robin pointer, previous request vector, and a queue of entries.
  int           m_owner;
  int           m_left;
  int           m_ptr;
  logic [N-1:0] m_prev;
  logic [N-1:0] m_q [$];
  logic         m_ovf;

  function automatic int rr_pick(input logic [N-1:0] v, input int p);
    for (int k = 1; k <= N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_left  = 0;
    m_ptr   = N - 1;
    m_prev  = '0;
    m_q.delete();
    m_ovf   = 1'b0;
  endtask

  task automatic model_step(input logic [N-1:0] r, input logic [N*WW-1:0] w);
    logic [N-1:0] arr;
    logic [N-1:0] rq;
    logic [N-1:0] hd;
    logic [WW-1:0] wv;
    bit ending;
    bit fresh;
    int nxt;
    rq = '0;
    ending = 0;
    fresh = 0;
    nxt = -1;
    if (m_owner >= 0) begin
      if (!r[m_owner]) ending = 1;
      else if (m_left == 1) begin
        ending = 1;
        rq[m_owner] = 1'b1;
      end
    end
    arr = (r & ~m_prev) | rq;
    foreach (m_q[k]) m_q[k] = m_q[k] & r;
    m_ovf = 1'b0;
    if (m_owner >= 0 && !ending) begin
      nxt = m_owner;
      m_left--;
    end else if (m_owner < 0 && m_q.size() == 0) begin
      nxt = rr_pick(arr, m_ptr);
      if (nxt >= 0) begin
        arr[nxt] = 1'b0;
        fresh = 1;
      end
    end else if (m_q.size() > 0) begin
      hd = m_q[0];
      nxt = rr_pick(hd, m_ptr);
      if (nxt >= 0) begin
        hd[nxt] = 1'b0;
        fresh = 1;
      end
      m_q[0] = hd;
      if (hd == '0) void'(m_q.pop_front());
    end
    if (fresh) begin
      m_owner = nxt;
      m_ptr   = nxt;
      wv      = w[nxt*WW +: WW];
      m_left  = (wv == 0) ? 1 : int'(wv);
    end else if (nxt < 0) begin
      m_owner = -1;
      m_left  = 0;
    end
    if (arr != '0) begin
      if (m_q.size() == DEPTH) begin
        m_q[DEPTH-1] = m_q[DEPTH-1] | arr;
        m_ovf = 1'b1;
      end else begin
        m_q.push_back(arr);
      end
    end
    m_prev = r;
  endtask

  function automatic logic [N-1:0] exp_grant();
    logic [N-1:0] g;
    g = '0;
    if (m_owner >= 0) g[m_owner] = 1'b1;
    return g & req;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      if (!rst_n) model_reset();
      else model_step(req, weight);
      #1;
      check("grant", 32'(grant), 32'(exp_grant()));
      if (m_owner >= 0) check("grant_id", 32'(grant_id), 32'(m_owner));
      check("queue_empty", 32'(queue_empty), 32'(m_q.size() == 0));
      check("queue_full", 32'(queue_full), 32'(m_q.size() == DEPTH));
      check("overflow", 32'(overflow), 32'(m_ovf));
    end
  endtask

  task automatic set(input logic [N-1:0] r, input logic [N*WW-1:0] w);
    req = r;
    weight = w;
    #1;
    check("grant_comb", 32'(grant), 32'(exp_grant()));
  endtask

  initial begin
    logic [N-1:0]    r;
    logic [N*WW-1:0] w;
    model_reset();
    rst_n  = 1'b0;
    req    = '0;
    weight = '0;

    // Reset state
    tick(2);
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_grant_id", 32'(grant_id), 32'h0);
    check("rst_empty", 32'(queue_empty), 32'h1);
    check("rst_full", 32'(queue_full), 32'h0);
    check("rst_overflow", 32'(overflow), 32'h0);
    rst_n = 1'b1;

    // Single request, weight 3: bypass, 3-cycle tenure, one-cycle gap, regrant
    set(4'b0001, 16'h1113);
    tick(1);
    check("bypass_latency", 32'(grant), 32'h1);
    tick(2);
    check("tenure_third", 32'(grant), 32'h1);
    tick(1);
    check("tenure_gap", 32'(grant), 32'h0);
    check("requeue_entry", 32'(queue_empty), 32'h0);
    tick(1);
    check("requeue_regrant", 32'(grant), 32'h1);
    set(4'b0000, 16'h1113);
    check("withdraw_comb", 32'(grant), 32'h0);
    tick(3);

    // FCFS across cycles behind a long ch2 tenure
    set(4'b0100, 16'h1811);
    tick(1);
    set(4'b1100, 16'h1811);
    tick(1);
    set(4'b1101, 16'h1811);
    tick(10);
    set(4'b0000, 16'h1811);
    tick(3);

    // Same-cycle tie after ch1 was last granted
    set(4'b0010, 16'h1111);
    tick(2);
    set(4'b0000, 16'h1111);
    tick(2);
    set(4'b0110, 16'h1111);
    tick(6);
    set(4'b0000, 16'h1111);
    tick(3);

    // Withdrawal of a queued request, leaving an empty head
    set(4'b0001, 16'h1116);
    tick(1);
    set(4'b0011, 16'h1116);
    tick(1);
    set(4'b0001, 16'h1116);
    tick(8);
    set(4'b0000, 16'h1116);
    tick(3);

    // Overflow: fill four entries behind ch0, fifth arrival merges into tail
    set(4'b0001, 16'h111F);
    tick(1);
    set(4'b0011, 16'h111F);
    tick(1);
    set(4'b0111, 16'h111F);
    tick(1);
    set(4'b1111, 16'h111F);
    tick(1);
    set(4'b1101, 16'h111F);
    tick(1);
    set(4'b1111, 16'h111F);
    tick(1);
    check("full_before_merge", 32'(queue_full), 32'h1);
    set(4'b1011, 16'h111F);
    tick(1);
    set(4'b1111, 16'h111F);
    tick(1);
    check("overflow_pulse", 32'(overflow), 32'h1);
    tick(1);
    check("overflow_clear", 32'(overflow), 32'h0);
    tick(30);
    set(4'b0000, 16'h111F);
    tick(4);

    // Reset during a tenure with three queued entries
    set(4'b0001, 16'h222A);
    tick(1);
    set(4'b0011, 16'h222A);
    tick(1);
    set(4'b0111, 16'h222A);
    tick(1);
    set(4'b1111, 16'h222A);
    tick(1);
    rst_n = 1'b0;
    tick(1);
    check("midrst_grant", 32'(grant), 32'h0);
    check("midrst_empty", 32'(queue_empty), 32'h1);
    rst_n = 1'b1;
    tick(1);
    check("post_rst_grant", 32'(grant), 32'h1);
    tick(12);
    set(4'b0000, 16'h222A);
    tick(3);

    // Randomized traffic
    for (int c = 0; c < 800; c++) begin
      r = req;
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
      end
      for (int b = 0; b < N; b++) w[b*WW +: WW] = WW'($urandom_range(0, 6));
      rst_n = ($urandom_range(0, 299) != 0);
      set(r, w);
      tick(1);
    end
    rst_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
